// File: rtl/dither_pkg.sv
// rtl/dither_pkg.sv - shared types and constants for the dither sequencer
// Contents: top-level state encoding (also driven onto state_dbg), per-pixel
// phase encoding, error arithmetic width, threshold, diffusion weights and the
// weighted-shift helper used by fs_quantize.
package dither_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_CLEAR  = 3'd2,
    S_DITHER = 3'd3,
    S_UNLOAD = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // Three-cycle pixel cadence; UNLOAD reuses it as issue / capture / present.
  typedef enum logic [1:0] {
    P_RD = 2'd0,
    P_WT = 2'd1,
    P_WR = 2'd2
  } phase_t;

  localparam int ERR_W     = 12;
  localparam int THRESH    = 128;
  localparam int PIX_MAX   = 255;
  localparam int W_RIGHT   = 7;
  localparam int W_BL      = 3;
  localparam int W_B       = 5;
  localparam int W_BR      = 1;
  localparam int ERR_SHIFT = 4;

  // (e * w) >>> 4 : arithmetic shift, so negative errors floor toward -inf.
  function automatic logic signed [ERR_W-1:0] diffuse_term(
    input logic signed [ERR_W-1:0] e,
    input int                      w
  );
    logic signed [ERR_W-1:0] p;
    p = e * $signed(ERR_W'(w));
    return p >>> ERR_SHIFT;
  endfunction

endpackage

// File: rtl/fs_quantize.sv
// rtl/fs_quantize.sv - combinational Floyd-Steinberg quantiser for one pixel
// Ports:
//   i_pixel   in  RGB_SIZE  raw pixel read from RAM
//   i_carry   in  ERR_W     error carried from the left neighbour
//   i_cur_err in  ERR_W     error accumulated from the row above
//   o_q       out RGB_SIZE  quantised pixel (all ones or all zeros)
//   o_t_right out ERR_W     (7e)>>>4, right neighbour
//   o_t_bl    out ERR_W     (3e)>>>4, below-left
//   o_t_b     out ERR_W     (5e)>>>4, below
//   o_t_br    out ERR_W     (1e)>>>4, below-right
module fs_quantize
  import dither_pkg::*;
#(
  parameter int RGB_SIZE = 8
) (
  input  logic        [RGB_SIZE-1:0] i_pixel,
  input  logic signed [ERR_W-1:0]    i_carry,
  input  logic signed [ERR_W-1:0]    i_cur_err,
  output logic        [RGB_SIZE-1:0] o_q,
  output logic signed [ERR_W-1:0]    o_t_right,
  output logic signed [ERR_W-1:0]    o_t_bl,
  output logic signed [ERR_W-1:0]    o_t_b,
  output logic signed [ERR_W-1:0]    o_t_br
);

  localparam logic signed [ERR_W-1:0] C_ZERO = '0;
  localparam logic signed [ERR_W-1:0] C_MAX  = ERR_W'(PIX_MAX);
  localparam logic signed [ERR_W-1:0] C_THR  = ERR_W'(THRESH);

  logic signed [ERR_W-1:0] w_v;
  logic signed [ERR_W-1:0] w_clamp;
  logic signed [ERR_W-1:0] w_qv;
  logic signed [ERR_W-1:0] w_e;
  logic                    w_white;

  always_comb begin
    w_v = $signed({{(ERR_W-RGB_SIZE){1'b0}}, i_pixel}) + i_carry + i_cur_err;
    if (w_v < C_ZERO) begin
      w_clamp = C_ZERO;
    end else if (w_v > C_MAX) begin
      w_clamp = C_MAX;
    end else begin
      w_clamp = w_v;
    end
    w_white   = (w_clamp >= C_THR);
    w_qv      = w_white ? C_MAX : C_ZERO;
    w_e       = w_clamp - w_qv;
    o_q       = w_white ? {RGB_SIZE{1'b1}} : {RGB_SIZE{1'b0}};
    o_t_right = diffuse_term(w_e, W_RIGHT);
    o_t_bl    = diffuse_term(w_e, W_BL);
    o_t_b     = diffuse_term(w_e, W_B);
    o_t_br    = diffuse_term(w_e, W_BR);
  end

endmodule

// File: rtl/dither_sequencer.sv
// rtl/dither_sequencer.sv - frame controller: SPI load, in-place FS dither, SPI readout
// Optional feature macro: DITHER_STATS_EN (adds white_count).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    begin a frame (sampled in IDLE only)
//   load_valid/data/ready    incoming SPI byte stream
//   out_valid/data/ready     outgoing SPI byte stream
//   mem_addr/wr_en/wdata     single-port pixel RAM request
//   mem_rdata                RAM read data, one cycle after address
//   busy, done, state_dbg    status for LEDs/HEX
//   white_count              number of white pixels written (DITHER_STATS_EN)
module dither_sequencer
  import dither_pkg::*;
#(
  parameter int IMAGEX     = 64,
  parameter int IMAGEY     = 64,
  parameter int IMAGE_SIZE = IMAGEX * IMAGEY,
  parameter int RGB_SIZE   = 8,
  parameter int ADDR_W     = $clog2(IMAGE_SIZE)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                load_valid,
  input  logic [RGB_SIZE-1:0] load_data,
  output logic                load_ready,
  output logic                out_valid,
  output logic [RGB_SIZE-1:0] out_data,
  input  logic                out_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wr_en,
  output logic [RGB_SIZE-1:0] mem_wdata,
  input  logic [RGB_SIZE-1:0] mem_rdata,
  output logic                busy,
  output logic                done,
  output logic [2:0]          state_dbg
`ifdef DITHER_STATS_EN
  ,
  output logic [ADDR_W:0]     white_count
`endif
);

  localparam int XW = (IMAGEX > 1) ? $clog2(IMAGEX) : 1;
  localparam int YW = (IMAGEY > 1) ? $clog2(IMAGEY) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMAGE_SIZE - 1);
  localparam logic [XW-1:0]     LAST_X    = XW'(IMAGEX - 1);
  localparam logic [YW-1:0]     LAST_Y    = YW'(IMAGEY - 1);

  state_t                  r_state;
  phase_t                  r_ph;
  logic [XW-1:0]           r_x;
  logic [YW-1:0]           r_y;
  logic [ADDR_W-1:0]       r_addr;
  logic signed [ERR_W-1:0] r_carry;
  logic                    r_sel;
  logic [RGB_SIZE-1:0]     r_pix;
  logic                    r_out_valid;
  logic [RGB_SIZE-1:0]     r_out_data;
  // Two row buffers; r_sel picks which one is "current" (row being dithered).
  logic signed [ERR_W-1:0] r_err0 [IMAGEX];
  logic signed [ERR_W-1:0] r_err1 [IMAGEX];
`ifdef DITHER_STATS_EN
  logic [ADDR_W:0]         r_white_cnt;
`endif

  logic                    w_x_last;
  logic                    w_y_last;
  logic                    w_a_last;
  logic [XW-1:0]           w_xm1;
  logic [XW-1:0]           w_xp1;
  logic signed [ERR_W-1:0] w_cur_err;
  logic signed [ERR_W-1:0] w_nxt_m1;
  logic signed [ERR_W-1:0] w_nxt_x;
  logic signed [ERR_W-1:0] w_new_bl;
  logic signed [ERR_W-1:0] w_new_b;
  logic [RGB_SIZE-1:0]     w_q;
  logic signed [ERR_W-1:0] w_t_right;
  logic signed [ERR_W-1:0] w_t_bl;
  logic signed [ERR_W-1:0] w_t_b;
  logic signed [ERR_W-1:0] w_t_br;

  assign w_x_last  = (r_x == LAST_X);
  assign w_y_last  = (r_y == LAST_Y);
  assign w_a_last  = (r_addr == LAST_ADDR);
  assign w_xm1     = (r_x == '0) ? '0 : r_x - XW'(1);
  assign w_xp1     = w_x_last ? r_x : r_x + XW'(1);
  assign w_cur_err = r_sel ? r_err1[r_x]   : r_err0[r_x];
  assign w_nxt_m1  = r_sel ? r_err0[w_xm1] : r_err1[w_xm1];
  assign w_nxt_x   = r_sel ? r_err0[r_x]   : r_err1[r_x];

  fs_quantize #(
    .RGB_SIZE (RGB_SIZE)
  ) u_quantize (
    .i_pixel   (r_pix),
    .i_carry   (r_carry),
    .i_cur_err (w_cur_err),
    .o_q       (w_q),
    .o_t_right (w_t_right),
    .o_t_bl    (w_t_bl),
    .o_t_b     (w_t_b),
    .o_t_br    (w_t_br)
  );

  // The next-row buffer still holds the row before last; each entry is
  // overwritten (not accumulated) the first time it is touched in a row.
  // Entry x+1 is first touched at pixel x, entry 0 at pixel 0.
  assign w_new_bl = w_nxt_m1 + w_t_bl;
  assign w_new_b  = (r_x == '0) ? w_t_b : w_nxt_x + w_t_b;

  // RAM request muxed by phase so only one phase can ever drive it.
  always_comb begin
    mem_addr  = '0;
    mem_wr_en = 1'b0;
    mem_wdata = '0;
    case (r_state)
      S_LOAD: begin
        mem_addr  = r_addr;
        mem_wr_en = load_valid;
        mem_wdata = load_data;
      end
      S_DITHER: begin
        mem_addr  = r_addr;
        mem_wr_en = (r_ph == P_WR);
        mem_wdata = (r_ph == P_WR) ? w_q : '0;
      end
      S_UNLOAD: begin
        mem_addr = r_addr;
      end
      default: begin
        mem_addr  = '0;
        mem_wr_en = 1'b0;
        mem_wdata = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ph        <= P_RD;
      r_x         <= '0;
      r_y         <= '0;
      r_addr      <= '0;
      r_carry     <= '0;
      r_sel       <= 1'b0;
      r_pix       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
`ifdef DITHER_STATS_EN
      r_white_cnt <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOAD;
            r_addr  <= '0;
`ifdef DITHER_STATS_EN
            r_white_cnt <= '0;
`endif
          end
        end

        S_LOAD: begin
          if (load_valid) begin
            if (w_a_last) begin
              r_state <= S_CLEAR;
              r_addr  <= '0;
              r_x     <= '0;
            end else begin
              r_addr <= r_addr + ADDR_W'(1);
            end
          end
        end

        S_CLEAR: begin
          r_err0[r_x] <= '0;
          r_err1[r_x] <= '0;
          if (w_x_last) begin
            r_state <= S_DITHER;
            r_ph    <= P_RD;
            r_x     <= '0;
            r_y     <= '0;
            r_addr  <= '0;
            r_carry <= '0;
            r_sel   <= 1'b0;
          end else begin
            r_x <= r_x + XW'(1);
          end
        end

        S_DITHER: begin
          case (r_ph)
            P_RD: r_ph <= P_WT;
            P_WT: begin
              r_pix <= mem_rdata;
              r_ph  <= P_WR;
            end
            P_WR: begin
              r_ph   <= P_RD;
              r_addr <= r_addr + ADDR_W'(1);
`ifdef DITHER_STATS_EN
              if (w_q[RGB_SIZE-1]) begin
                r_white_cnt <= r_white_cnt + {{ADDR_W{1'b0}}, 1'b1};
              end
`endif
              // The last row has nowhere to push its error.
              if (!w_y_last) begin
                if (r_sel) begin
                  if (r_x != '0) r_err0[w_xm1] <= w_new_bl;
                  r_err0[r_x] <= w_new_b;
                  if (!w_x_last) r_err0[w_xp1] <= w_t_br;
                end else begin
                  if (r_x != '0) r_err1[w_xm1] <= w_new_bl;
                  r_err1[r_x] <= w_new_b;
                  if (!w_x_last) r_err1[w_xp1] <= w_t_br;
                end
              end
              if (w_x_last) begin
                r_x     <= '0;
                r_carry <= '0;
                r_sel   <= ~r_sel;
                if (w_y_last) begin
                  r_state <= S_UNLOAD;
                  r_addr  <= '0;
                end else begin
                  r_y <= r_y + YW'(1);
                end
              end else begin
                r_x     <= r_x + XW'(1);
                r_carry <= w_t_right;
              end
            end
            default: r_ph <= P_RD;
          endcase
        end

        S_UNLOAD: begin
          case (r_ph)
            P_RD: r_ph <= P_WT;
            P_WT: begin
              r_out_data  <= mem_rdata;
              r_out_valid <= 1'b1;
              r_ph        <= P_WR;
            end
            P_WR: begin
              // out_data is a register, so it stays put while the consumer stalls.
              if (out_ready) begin
                r_out_valid <= 1'b0;
                r_ph        <= P_RD;
                if (w_a_last) begin
                  r_state <= S_DONE;
                  r_addr  <= '0;
                end else begin
                  r_addr <= r_addr + ADDR_W'(1);
                end
              end
            end
            default: r_ph <= P_RD;
          endcase
        end

        S_DONE: r_state <= S_IDLE;

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign load_ready = (r_state == S_LOAD);
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign state_dbg  = r_state;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
`ifdef DITHER_STATS_EN
  assign white_count = r_white_cnt;
`endif

endmodule

// File: tb/tb_dither_sequencer.sv
// tb/tb_dither_sequencer.sv - self-checking bench for dither_sequencer on a 4x2 frame
module tb_dither_sequencer;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int N  = W * H;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          load_valid = 1'b0;
  logic [7:0]    load_data = 8'h00;
  logic          load_ready;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          out_ready = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_en;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;
  logic          busy;
  logic          done;
  logic [2:0]    state_dbg;
`ifdef DITHER_STATS_EN
  logic [AW:0]   white_count;
`endif

  dither_sequencer #(
    .IMAGEX (W),
    .IMAGEY (H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .mem_addr   (mem_addr),
    .mem_wr_en  (mem_wr_en),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .done       (done),
    .state_dbg  (state_dbg)
`ifdef DITHER_STATS_EN
    ,
    .white_count (white_count)
`endif
  );

  always #5 clk = ~clk;

  // Single-port RAM, registered read.
  logic [7:0] ram [N];
  always @(posedge clk) begin
    if (mem_wr_en) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int n_checks = 0;
  int n_pass   = 0;

  int img [N];
  int expv [N];
  int exp_white;
  int got [N];
  int lat, done_cnt, oi, stab_err, timed_out, stall_seen;

  // Whole-frame reference: a full HxW error plane, no row buffers or phases.
  function automatic void fs_model();
    int err [H][W];
    int carry, v, q, e;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) err[y][x] = 0;
    exp_white = 0;
    for (int y = 0; y < H; y++) begin
      carry = 0;
      for (int x = 0; x < W; x++) begin
        v = img[y*W+x] + carry + err[y][x];
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        q = (v >= 128) ? 255 : 0;
        e = v - q;
        expv[y*W+x] = q;
        if (q == 255) exp_white++;
        carry = (x < W-1) ? ((7*e) >>> 4) : 0;
        if (y < H-1) begin
          if (x > 0) err[y+1][x-1] += (3*e) >>> 4;
          err[y+1][x] += (5*e) >>> 4;
          if (x < W-1) err[y+1][x+1] += e >>> 4;
        end
      end
    end
  endfunction

  // mode 0: no back-pressure, 1: random gaps both sides, 2: 5-cycle stall at byte 3
  task automatic run_frame(input int mode);
    int li, stall_n;
    bit prev_hold, seen_done, finished, rdy;
    logic [7:0] prev_data;
    li = 0; oi = 0; lat = 0; done_cnt = 0; stab_err = 0; stall_n = 0;
    prev_hold = 0; seen_done = 0; finished = 0; prev_data = 8'h00;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (state_dbg == 3'd2 || state_dbg == 3'd3) lat++;
      if (done) begin
        done_cnt++;
        seen_done = 1;
      end else if (seen_done && state_dbg == 3'd0) begin
        finished = 1;
        break;
      end
      if (li < N) begin
        load_valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        load_data  = 8'(img[li]);
      end else begin
        load_valid = 1'b0;
      end
      if (load_valid && load_ready) li++;
      rdy = 1'b1;
      if (mode == 1) rdy = ($urandom_range(0, 2) != 0);
      if (mode == 2 && oi == 3 && stall_n < 5 && (out_valid || stall_n > 0)) begin
        rdy = 1'b0;
        stall_n++;
      end
      out_ready = rdy;
      if (prev_hold && (!out_valid || out_data !== prev_data)) stab_err++;
      if (out_valid && !out_ready) begin
        prev_hold = 1;
        prev_data = out_data;
      end else begin
        prev_hold = 0;
      end
      if (out_valid && out_ready) begin
        if (oi < N) got[oi] = int'(out_data);
        oi++;
      end
      @(negedge clk);
    end
    load_valid = 1'b0;
    out_ready  = 1'b0;
    timed_out  = finished ? 0 : 1;
    stall_seen = stall_n;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (state_dbg !== 3'd0) $display("FAIL reset_state got=%0d want=0", state_dbg); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b want=0", done); else n_pass++;
    n_checks++; if (load_ready !== 1'b0) $display("FAIL reset_load_ready got=%b want=0", load_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid); else n_pass++;
    n_checks++; if (mem_wr_en !== 1'b0) $display("FAIL reset_mem_wr_en got=%b want=0", mem_wr_en); else n_pass++;
    n_checks++; if (mem_addr !== '0) $display("FAIL reset_mem_addr got=%0d want=0", mem_addr); else n_pass++;
`ifdef DITHER_STATS_EN
    n_checks++; if (white_count !== '0) $display("FAIL reset_white got=%0d want=0", white_count); else n_pass++;
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zeros();
    for (int i = 0; i < N; i++) img[i] = 0;
    fs_model();
    run_frame(0);
    n_checks++; if (timed_out !== 0) $display("FAIL zeros_timeout got=%0d want=0", timed_out); else n_pass++;
    n_checks++; if (lat !== W + 3*N) $display("FAIL zeros_latency got=%0d want=%0d", lat, W + 3*N); else n_pass++;
    n_checks++; if (done_cnt !== 1) $display("FAIL zeros_done_pulses got=%0d want=1", done_cnt); else n_pass++;
    n_checks++; if (oi !== N) $display("FAIL zeros_count got=%0d want=%0d", oi, N); else n_pass++;
    for (int i = 0; i < N; i++) begin
      n_checks++; if (got[i] !== expv[i]) $display("FAIL zeros_byte[%0d] got=%0d want=%0d", i, got[i], expv[i]); else n_pass++;
    end
  endtask

  task automatic test_ones();
    for (int i = 0; i < N; i++) img[i] = 255;
    fs_model();
    run_frame(0);
    n_checks++; if (oi !== N) $display("FAIL ones_count got=%0d want=%0d", oi, N); else n_pass++;
    for (int i = 0; i < N; i++) begin
      n_checks++; if (got[i] !== 255) $display("FAIL ones_byte[%0d] got=%0d want=255", i, got[i]); else n_pass++;
    end
`ifdef DITHER_STATS_EN
    n_checks++; if (white_count !== 4'(N)) $display("FAIL ones_white got=%0d want=%0d", white_count, N); else n_pass++;
    @(negedge clk);
    n_checks++; if (white_count !== 4'(N)) $display("FAIL ones_white_idle got=%0d want=%0d", white_count, N); else n_pass++;
`endif
  endtask

  task automatic test_single_pixel();
    for (int i = 0; i < N; i++) img[i] = 0;
    img[0] = 100;
    fs_model();
    run_frame(0);
    n_checks++; if (done_cnt !== 1) $display("FAIL single_done got=%0d want=1", done_cnt); else n_pass++;
    for (int i = 0; i < N; i++) begin
      n_checks++; if (got[i] !== expv[i]) $display("FAIL single_byte[%0d] got=%0d want=%0d", i, got[i], expv[i]); else n_pass++;
    end
  endtask

  task automatic test_mid_gray();
    for (int i = 0; i < N; i++) img[i] = 128;
    fs_model();
    run_frame(0);
    n_checks++; if (got[0] !== 255) $display("FAIL mid_first got=%0d want=255", got[0]); else n_pass++;
    for (int i = 0; i < N; i++) begin
      n_checks++; if (got[i] !== expv[i]) $display("FAIL mid_byte[%0d] got=%0d want=%0d", i, got[i], expv[i]); else n_pass++;
    end
`ifdef DITHER_STATS_EN
    n_checks++; if (white_count !== 4'(exp_white)) $display("FAIL mid_white got=%0d want=%0d", white_count, exp_white); else n_pass++;
`endif
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < N; i++) img[i] = $urandom_range(0, 255);
      fs_model();
      run_frame(1);
      n_checks++; if (timed_out !== 0) $display("FAIL rand%0d_timeout got=%0d want=0", f, timed_out); else n_pass++;
      n_checks++; if (done_cnt !== 1) $display("FAIL rand%0d_done got=%0d want=1", f, done_cnt); else n_pass++;
      n_checks++; if (oi !== N) $display("FAIL rand%0d_count got=%0d want=%0d", f, oi, N); else n_pass++;
      n_checks++; if (stab_err !== 0) $display("FAIL rand%0d_hold got=%0d want=0", f, stab_err); else n_pass++;
      for (int i = 0; i < N; i++) begin
        n_checks++; if (got[i] !== expv[i]) $display("FAIL rand%0d_byte[%0d] got=%0d want=%0d", f, i, got[i], expv[i]); else n_pass++;
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < N; i++) img[i] = $urandom_range(60, 200);
    fs_model();
    run_frame(2);
    n_checks++; if (stall_seen !== 5) $display("FAIL stall_cycles got=%0d want=5", stall_seen); else n_pass++;
    n_checks++; if (stab_err !== 0) $display("FAIL stall_hold got=%0d want=0", stab_err); else n_pass++;
    n_checks++; if (oi !== N) $display("FAIL stall_count got=%0d want=%0d", oi, N); else n_pass++;
    for (int i = 0; i < N; i++) begin
      n_checks++; if (got[i] !== expv[i]) $display("FAIL stall_byte[%0d] got=%0d want=%0d", i, got[i], expv[i]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_dither();
    int li;
    bit reached;
    for (int i = 0; i < N; i++) img[i] = $urandom_range(0, 255);
    li = 0; reached = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (state_dbg == 3'd3) begin
        reached = 1;
        break;
      end
      load_valid = (li < N);
      load_data  = 8'(img[li % N]);
      if (load_valid && load_ready) li++;
      @(negedge clk);
    end
    load_valid = 1'b0;
    n_checks++; if (reached !== 1'b1) $display("FAIL abort_reach_dither got=%b want=1", reached); else n_pass++;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (state_dbg !== 3'd0) $display("FAIL abort_state got=%0d want=0", state_dbg); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy got=%b want=0", busy); else n_pass++;
    n_checks++; if (mem_wr_en !== 1'b0) $display("FAIL abort_wr_en got=%b want=0", mem_wr_en); else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < N; i++) img[i] = $urandom_range(0, 255);
    fs_model();
    run_frame(0);
    n_checks++; if (lat !== W + 3*N) $display("FAIL rerun_latency got=%0d want=%0d", lat, W + 3*N); else n_pass++;
    n_checks++; if (done_cnt !== 1) $display("FAIL rerun_done got=%0d want=1", done_cnt); else n_pass++;
    for (int i = 0; i < N; i++) begin
      n_checks++; if (got[i] !== expv[i]) $display("FAIL rerun_byte[%0d] got=%0d want=%0d", i, got[i], expv[i]); else n_pass++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d passed=%0d", n_checks, n_pass);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_zeros();
    test_ones();
    test_single_pixel();
    test_mid_gray();
    test_random_frames();
    test_stall();
    test_reset_mid_dither();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
